// File: rtl/mem_pkg.sv
// +-----------------------------------------------------------------------------+
// | mem_pkg : shared types and helpers for the multi-port memory arbiter        |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

package mem_pkg;

    typedef enum logic [1:0] {
        OP_B   = 2'b00,
        OP_H   = 2'b01,
        OP_RSV = 2'b10,
        OP_W   = 2'b11
    } oplen_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_e;

    localparam int c_WORD_W = 32;

    function automatic logic [3:0] byte_en(input oplen_e op, input logic [1:0] lo);
        case (op)
            OP_B:    byte_en = 4'b0001 << lo;
            OP_H:    byte_en = lo[1] ? 4'b1100 : 4'b0011;
            OP_W:    byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    endfunction

    function automatic logic misaligned(input oplen_e op, input logic [1:0] lo);
        case (op)
            OP_H:    misaligned = lo[0];
            OP_W:    misaligned = |lo;
            default: misaligned = 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_extend.sv
// +-----------------------------------------------------------------------------+
// | load_extend : selects the addressed byte/half of a RAM word and extends it  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  oplen_e      i_oplen,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_word[{i_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        o_data = i_word;
        case (i_oplen)
            OP_B:    o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            OP_H:    o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// +-----------------------------------------------------------------------------+
// | mem_port_arbiter : round-robin N-channel front end to a single word RAM     |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_W      = 25,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req_valid,
    output logic [NUM_PORTS-1:0]        req_ready,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS-1:0]        req_we,
    input  logic [NUM_PORTS*2-1:0]      req_oplen,
    input  logic [NUM_PORTS-1:0]        req_unsigned,
    input  logic [NUM_PORTS*32-1:0]     req_wdata,
    output logic [NUM_PORTS-1:0]        rsp_valid,
    output logic [NUM_PORTS*32-1:0]     rsp_data,
    output logic [NUM_PORTS-1:0]        rsp_err
);

    localparam int c_PTR_W = (NUM_PORTS > 1)   ? $clog2(NUM_PORTS)   : 1;
    localparam int c_IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int c_CNT_W = (LATENCY > 1)     ? $clog2(LATENCY)     : 1;

    state_e               r_state, w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [c_PTR_W-1:0]   r_rr_ptr, w_rr_nxt;

    logic [c_PTR_W-1:0]   r_id;
    logic [1:0]           r_addr_lo;
    oplen_e               r_oplen;
    logic                 r_unsigned;
    logic                 r_we;
    logic                 r_err;
    logic [31:0]          r_word;

    logic [31:0]          r_mem [DEPTH_WORDS];

    logic                 w_found;
    logic [c_PTR_W-1:0]   w_gnt;
    logic                 w_accept;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic                 w_sel_we;
    oplen_e               w_sel_oplen;
    logic                 w_sel_unsigned;
    logic [31:0]          w_sel_wdata;
    logic [ADDR_W-3:0]    w_word_idx;
    logic [c_IDX_W-1:0]   w_ram_idx;
    logic                 w_err;
    logic [3:0]           w_be;
    logic [31:0]          w_wdata_rep;
    logic [31:0]          w_ext;

    // First requester at or after the rotating pointer wins.
    always_comb begin
        logic [c_PTR_W-1:0] w_cand;
        w_found = 1'b0;
        w_gnt   = '0;
        w_cand  = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_cand = c_PTR_W'((int'(r_rr_ptr) + k) % NUM_PORTS);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_gnt   = w_cand;
            end
        end
    end

    assign w_accept = (r_state == IDLE) && w_found && !rst;

    always_comb begin
        w_sel_addr     = '0;
        w_sel_we       = 1'b0;
        w_sel_oplen    = OP_B;
        w_sel_unsigned = 1'b0;
        w_sel_wdata    = '0;
        req_ready      = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_gnt == c_PTR_W'(p)) begin
                w_sel_addr     = req_addr[p*ADDR_W +: ADDR_W];
                w_sel_we       = req_we[p];
                w_sel_oplen    = oplen_e'(req_oplen[p*2 +: 2]);
                w_sel_unsigned = req_unsigned[p];
                w_sel_wdata    = req_wdata[p*32 +: 32];
                req_ready[p]   = w_accept;
            end
        end
    end

    assign w_word_idx = w_sel_addr[ADDR_W-1:2];
    assign w_ram_idx  = w_word_idx[c_IDX_W-1:0];
    assign w_err      = (w_word_idx >= (ADDR_W-2)'(DEPTH_WORDS))
                      | misaligned(w_sel_oplen, w_sel_addr[1:0])
                      | (w_sel_oplen == OP_RSV);
    assign w_be       = byte_en(w_sel_oplen, w_sel_addr[1:0]);

    always_comb begin
        case (w_sel_oplen)
            OP_B:    w_wdata_rep = {4{w_sel_wdata[7:0]}};
            OP_H:    w_wdata_rep = {2{w_sel_wdata[15:0]}};
            default: w_wdata_rep = w_sel_wdata;
        endcase
    end

    // Writes commit in the acceptance cycle, so a later reset cannot undo them.
    always_ff @(posedge clk) begin
        if (w_accept && w_sel_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_ram_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_id       <= w_gnt;
            r_addr_lo  <= w_sel_addr[1:0];
            r_oplen    <= w_sel_oplen;
            r_unsigned <= w_sel_unsigned;
            r_we       <= w_sel_we;
            r_err      <= w_err;
            r_word     <= w_err ? 32'd0 : r_mem[w_ram_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rr_ptr <= w_rr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rr_nxt    = r_rr_ptr;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_rr_nxt    = (w_gnt == c_PTR_W'(NUM_PORTS - 1)) ? '0 : w_gnt + 1'b1;
                    w_cnt_nxt   = c_CNT_W'(LATENCY - 1);
                    w_state_nxt = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    load_extend u_load_extend (
        .i_word     (r_word),
        .i_addr_lo  (r_addr_lo),
        .i_oplen    (r_oplen),
        .i_unsigned (r_unsigned),
        .o_data     (w_ext)
    );

    // Response is suppressed while rst is high so a dropped access never pulses.
    always_comb begin
        rsp_valid = '0;
        rsp_err   = '0;
        rsp_data  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (!rst && (r_state == RESP) && (r_id == c_PTR_W'(p))) begin
                rsp_valid[p]         = 1'b1;
                rsp_err[p]           = r_err;
                rsp_data[p*32 +: 32] = (r_err || r_we) ? 32'd0 : w_ext;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// +-----------------------------------------------------------------------------+
// | tb_mem_port_arbiter : directed + randomized bench with byte-level RAM model |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_port_arbiter;

    localparam int NP  = 3;
    localparam int AW  = 25;
    localparam int DW  = 64;
    localparam int LAT = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NP-1:0]     req_valid = '0;
    logic [NP-1:0]     req_ready;
    logic [NP*AW-1:0]  req_addr = '0;
    logic [NP-1:0]     req_we = '0;
    logic [NP*2-1:0]   req_oplen = '0;
    logic [NP-1:0]     req_unsigned = '0;
    logic [NP*32-1:0]  req_wdata = '0;
    logic [NP-1:0]     rsp_valid;
    logic [NP*32-1:0]  rsp_data;
    logic [NP-1:0]     rsp_err;

    mem_port_arbiter #(
        .NUM_PORTS   (NP),
        .ADDR_W      (AW),
        .DEPTH_WORDS (DW),
        .LATENCY     (LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_we       (req_we),
        .req_oplen    (req_oplen),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_errors = 0;
    longint cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: byte-addressed memory, timestamps for busy/response.
    logic [7:0]  mm [DW*4];
    int          rr = 0;
    longint      free_at = 0;
    bit          pend = 0;
    longint      pend_cyc = 0;
    int          pid = 0;
    logic [31:0] pdata = '0;
    bit          perr = 0;
    logic [NP-1:0] acc_seen = '0;

    task automatic model_access(input int p, output logic [31:0] d, output bit e);
        int ai  = int'(req_addr[p*AW +: AW]);
        int op  = int'(req_oplen[p*2 +: 2]);
        bit we  = req_we[p];
        bit uns = req_unsigned[p];
        logic [31:0] wd = req_wdata[p*32 +: 32];
        int v;
        e = (ai / 4 >= DW) || (op == 2) || (op == 1 && ai % 2 != 0) || (op == 3 && ai % 4 != 0);
        d = '0;
        if (!e) begin
            if (we) begin
                if (op == 0) mm[ai] = wd[7:0];
                if (op == 1) begin mm[ai] = wd[7:0]; mm[ai+1] = wd[15:8]; end
                if (op == 3) for (int i = 0; i < 4; i++) mm[ai+i] = wd[8*i +: 8];
            end else if (op == 0) begin
                v = int'(mm[ai]);
                if (!uns && v >= 128) v = v - 256;
                d = 32'(v);
            end else if (op == 1) begin
                v = int'(mm[ai]) + 256 * int'(mm[ai+1]);
                if (!uns && v >= 32768) v = v - 65536;
                d = 32'(v);
            end else begin
                d = {mm[ai+3], mm[ai+2], mm[ai+1], mm[ai]};
            end
        end
    endtask

    always @(negedge clk) begin
        logic [NP-1:0]    er, ev, ee;
        logic [NP*32-1:0] ed;
        bit               found;
        int               g;
        er = '0; ev = '0; ee = '0; ed = '0; found = 0; g = 0;
        if (rst) begin
            pend = 0; rr = 0; free_at = cyc + 1;
        end else begin
            if (pend && cyc == pend_cyc) begin
                ev[pid] = 1'b1; ee[pid] = perr; ed[pid*32 +: 32] = pdata; pend = 0;
            end
            if (cyc >= free_at) begin
                for (int k = 0; k < NP; k++) begin
                    if (!found && req_valid[(rr + k) % NP]) begin
                        found = 1; g = (rr + k) % NP;
                    end
                end
                if (found) begin
                    er[g] = 1'b1;
                    model_access(g, pdata, perr);
                    pid = g; pend = 1; pend_cyc = cyc + LAT + 1;
                    free_at = cyc + LAT + 2; rr = (g + 1) % NP;
                end
            end
        end
        chk("req_ready", req_ready, er);
        chk("rsp_valid", rsp_valid, ev);
        chk("rsp_err", rsp_err, ee);
        chk("rsp_data", rsp_data, ed);
        acc_seen = req_valid & req_ready;
    end

    task automatic set_req(input int p, input bit we, input logic [1:0] op, input bit uns,
                           input logic [AW-1:0] a, input logic [31:0] wd);
        req_we[p] = we; req_oplen[p*2 +: 2] = op; req_unsigned[p] = uns;
        req_addr[p*AW +: AW] = a; req_wdata[p*32 +: 32] = wd; req_valid[p] = 1'b1;
    endtask

    task automatic do_req(input int p, input bit we, input logic [1:0] op, input bit uns,
                          input logic [AW-1:0] a, input logic [31:0] wd, output longint ac);
        bit got = 0;
        ac = -1;
        set_req(p, we, op, uns, a, wd);
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (req_ready[p]) begin got = 1; ac = cyc; end
        end
        chk("accept_seen", got, 1);
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
    endtask

    task automatic expect_rsp(input int p, input logic [31:0] ed, input bit ee, output longint rc);
        bit got = 0;
        rc = -1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid[p]) begin
                got = 1; rc = cyc;
                chk("dir_data", rsp_data[p*32 +: 32], ed);
                chk("dir_err", rsp_err[p], ee);
            end
        end
        chk("rsp_seen", got, 1);
        @(posedge clk); #1;
    endtask

    task automatic new_req(input int p);
        logic [AW-1:0] a;
        if ($urandom_range(0, 9) == 0) a = AW'(DW*4 + $urandom_range(0, 255));
        else                           a = AW'($urandom_range(0, DW*4 - 1));
        set_req(p, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                a, $urandom);
    endtask

    typedef struct {
        int p; bit we; logic [1:0] op; bit uns; logic [AW-1:0] a; logic [31:0] wd;
        logic [31:0] ed; bit ee;
    } dir_t;

    dir_t dir [11] = '{
        '{0, 1'b1, 2'b11, 1'b0, 25'h10, 32'hDEADBEEF, 32'h0,        1'b0},
        '{0, 1'b0, 2'b11, 1'b0, 25'h10, 32'h0,        32'hDEADBEEF, 1'b0},
        '{0, 1'b1, 2'b00, 1'b0, 25'h13, 32'h80,       32'h0,        1'b0},
        '{0, 1'b0, 2'b00, 1'b0, 25'h13, 32'h0,        32'hFFFFFF80, 1'b0},
        '{0, 1'b0, 2'b00, 1'b1, 25'h13, 32'h0,        32'h00000080, 1'b0},
        '{0, 1'b0, 2'b11, 1'b0, 25'h10, 32'h0,        32'h80ADBEEF, 1'b0},
        '{1, 1'b0, 2'b01, 1'b0, 25'h11, 32'h0,        32'h0,        1'b1},
        '{1, 1'b1, 2'b11, 1'b0, 25'h12, 32'h12345678, 32'h0,        1'b1},
        '{1, 1'b0, 2'b11, 1'b0, 25'h10, 32'h0,        32'h80ADBEEF, 1'b0},
        '{2, 1'b0, 2'b11, 1'b0, 25'(DW*4), 32'h0,     32'h0,        1'b1},
        '{2, 1'b0, 2'b10, 1'b0, 25'h20, 32'h0,        32'h0,        1'b1}
    };

    initial begin
        longint ac, rc;
        int     gq[$];

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", req_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int w = 0; w < DW; w++) do_req(0, 1'b1, 2'b11, 1'b0, AW'(w*4), $urandom, ac);

        for (int i = 0; i < 11; i++) begin
            do_req(dir[i].p, dir[i].we, dir[i].op, dir[i].uns, dir[i].a, dir[i].wd, ac);
            expect_rsp(dir[i].p, dir[i].ed, dir[i].ee, rc);
            if (i == 1) chk("latency", rc - ac, LAT + 1);
        end

        // Reset lands while a port-1 read is in BUSY.
        do_req(1, 1'b0, 2'b11, 1'b0, 25'h10, 32'h0, ac);
        repeat (3) @(posedge clk); #1;
        rst = 1'b1;
        for (int p = 0; p < NP; p++) set_req(p, 1'b0, 2'b11, 1'b0, 25'h10, 32'h0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 200 && gq.size() < 6; i++) begin
            @(negedge clk);
            chk("ready_onehot", $onehot0(req_ready), 1);
            for (int p = 0; p < NP; p++) if (req_ready[p]) gq.push_back(p);
        end
        @(posedge clk); #1;
        req_valid = '0;
        chk("grant_count", gq.size(), 6);
        for (int i = 0; i < 6 && i < gq.size(); i++) chk("grant_order", gq[i], i % NP);
        repeat (LAT + 4) @(posedge clk); #1;

        for (int it = 0; it < 1500; it++) begin
            rst = (it >= 700 && it < 702);
            for (int p = 0; p < NP; p++) begin
                if (req_valid[p]) begin
                    if (acc_seen[p]) begin
                        req_valid[p] = 1'b0;
                        if ($urandom_range(0, 1) == 1) new_req(p);
                    end else if ($urandom_range(0, 19) == 0) begin
                        req_valid[p] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    new_req(p);
                end
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        req_valid = '0;
        repeat (LAT + 5) @(posedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
